// File: rtl/jk_bank_driver.sv
// Write-side controller for a bank of JK flip-flops: accepts a target word, drives one cycle of J/K
// excitation, settles, verifies Q readback and retries. Optional macro JK_TOGGLE_PREF_EN selects toggle-preferred excitation.
module jk_bank_driver #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_RETRY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] err_mask,
  output logic [2:0]       retry_cnt
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_busy;
  logic             r_done;
  logic             r_mis;
  logic [WIDTH-1:0] r_err;
  logic [2:0]       r_retry;
  logic [SW-1:0]    r_settle;

  logic [WIDTH-1:0] w_exc_t;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_accept;

  // Excitation target is the incoming word at accept and the latched word on retry.
  always_comb begin
    w_exc_t = (r_state == S_IDLE) ? tgt_data : r_tgt;
`ifdef JK_TOGGLE_PREF_EN
    w_j = q_fb | w_exc_t;
    w_k = ~(q_fb & w_exc_t);
`else
    w_j = ~q_fb & w_exc_t;
    w_k = q_fb & ~w_exc_t;
`endif
  end

  assign tgt_ready = (r_state == S_IDLE) && !r_busy && !rst;
  assign w_accept  = tgt_valid && tgt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tgt    <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mis    <= 1'b0;
      r_err    <= '0;
      r_retry  <= '0;
      r_settle <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tgt   <= tgt_data;
            r_j     <= w_j;
            r_k     <= w_k;
            r_retry <= '0;
            r_mis   <= 1'b0;
            r_err   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_j      <= '0;
          r_k      <= '0;
          r_settle <= SW'(SETTLE_CYC - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_CHECK;
          else                r_settle <= r_settle - SW'(1);
        end
        S_CHECK: begin
          if (q_fb == r_tgt) begin
            r_done  <= 1'b1;
            r_mis   <= 1'b0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_retry < 3'(MAX_RETRY)) begin
            r_retry <= r_retry + 3'd1;
            r_j     <= w_j;
            r_k     <= w_k;
            r_state <= S_DRIVE;
          end else begin
            r_done  <= 1'b1;
            r_mis   <= 1'b1;
            r_err   <= q_fb ^ r_tgt;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign j_out     = r_j;
  assign k_out     = r_k;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mismatch  = r_mis;
  assign err_mask  = r_err;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver: a behavioural JK bank with an injectable stuck-at-0
// readback mask, directed scenarios plus randomized targets checked against an operation-level model.
module tb_jk_bank_driver;
  localparam int W  = 4;
  localparam int SC = 1;
  localparam int MR = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt_data;
  logic [W-1:0] q_fb;
  logic [W-1:0] j_out, k_out;
  logic         busy, done, mismatch;
  logic [W-1:0] err_mask;
  logic [2:0]   retry_cnt;

  logic [W-1:0] bank_q;
  logic [W-1:0] stuck0;
  logic         preset_en;
  logic [W-1:0] preset_val;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .SETTLE_CYC(SC), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .q_fb(q_fb), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .mismatch(mismatch), .err_mask(err_mask),
    .retry_cnt(retry_cnt)
  );

  // Four JK flip-flops; stuck0 forces readback bits low without touching the stored state.
  always @(posedge clk) begin
    if (preset_en) bank_q <= preset_val;
    else
      for (int i = 0; i < W; i++)
        case ({j_out[i], k_out[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
  end
  assign q_fb = bank_q & ~stuck0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Excitation table lookup per bit, indexed by {q, target}; returns {J, K}.
  function automatic logic [2*W-1:0] ref_exc(input logic [W-1:0] q, input logic [W-1:0] t);
    logic [1:0] tbl [4];
    logic [W-1:0] jj, kk;
`ifdef JK_TOGGLE_PREF_EN
    tbl[0] = 2'b01; tbl[1] = 2'b11; tbl[2] = 2'b11; tbl[3] = 2'b10;
`else
    tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b01; tbl[3] = 2'b00;
`endif
    for (int i = 0; i < W; i++) begin
      jj[i] = tbl[{q[i], t[i]}][1];
      kk[i] = tbl[{q[i], t[i]}][0];
    end
    return {jj, kk};
  endfunction

  task automatic do_op(input logic [W-1:0] t, input logic [W-1:0] stuck, input bit hold);
    int n;
    bit seen;
    logic [2*W-1:0] ex;
    bit exp_mis;
    int exp_retry, exp_lat;
    @(negedge clk);
    stuck0 = stuck;
    #1;
    n = 0;
    while (!tgt_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(tgt_ready), 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = t;
    ex = ref_exc(q_fb, t);
    @(posedge clk); #1;
    chk("accept_j", 32'(j_out), 32'(ex[2*W-1:W]));
    chk("accept_k", 32'(k_out), 32'(ex[W-1:0]));
    chk("accept_busy", 32'(busy), 32'd1);
    if (!hold) tgt_valid = 1'b0;
    exp_mis   = (t & stuck) != '0;
    exp_retry = exp_mis ? MR : 0;
    exp_lat   = (exp_retry + 1) * (SC + 2);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("drive_clr", 32'({j_out, k_out}), 32'd0);
`ifndef JK_TOGGLE_PREF_EN
      chk("jk_excl", 32'(j_out & k_out), 32'd0);
`endif
      if (done) seen = 1'b1;
      else chk("ready_busy", 32'({tgt_ready, busy}), 32'b01);
    end
    tgt_valid = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("mismatch", 32'(mismatch), 32'(exp_mis));
    chk("err_mask", 32'(err_mask), 32'(t & stuck));
    chk("retry_cnt", 32'(retry_cnt), 32'(exp_retry));
    chk("done_ready", 32'({tgt_ready, busy}), 32'b10);
    chk("readback", 32'(q_fb), 32'(t & ~stuck));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("no_reaccept", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0; stuck0 = '0;
    preset_en = 1'b1; preset_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    preset_en = 1'b0;
    #1;
    chk("rst_jk", 32'({j_out, k_out}), 32'd0);
    chk("rst_flags", 32'({done, busy, mismatch}), 32'd0);
    chk("rst_err", 32'({err_mask, retry_cnt}), 32'd0);
    chk("rst_ready", 32'(tgt_ready), 32'd1);

    do_op(4'b1010, 4'b0000, 1'b0);
    do_op(4'b0110, 4'b0000, 1'b0);
    do_op(4'b0110, 4'b0000, 1'b1);
    do_op(4'b0001, 4'b0001, 1'b0);

    for (int r = 0; r < 24; r++)
      do_op(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
            1'($urandom_range(0, 1)));

    // Abort mid-operation by reset.
    @(negedge clk);
    stuck0 = '0;
    preset_en = 1'b1; preset_val = '0;
    @(negedge clk);
    preset_en = 1'b0;
    tgt_valid = 1'b1; tgt_data = 4'b1111;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    chk("abort_acc_j", 32'(j_out), 32'(ref_exc(4'b0000, 4'b1111) >> W));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_jk", 32'({j_out, k_out}), 32'd0);
    chk("abort_busy", 32'({busy, done, tgt_ready}), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("abort_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(tgt_ready), 32'd1);
    do_op(4'b0011, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
